rr_arb_mux_2x1: RTL and testbench

// - Two-requester round-robin arbiter and registered output stage that sits directly upstream of the 2x1 mux.
// - Decides `sel` each cycle and captures the selected operand into an output register.
// - Offers the result downstream with a valid/ready handshake.
// - `sel` follows the mux convention: 0 selects a, 1 selects b.

---
 rtl/rr_arb_mux_2x1.sv | 89 ++++++++
 tb/tb_rr_arb_mux_2x1.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_2x1.sv
// Two-requester round-robin arbiter with a registered, valid/ready output stage
// feeding the downstream 2x1 mux (sel: 0 = a, 1 = b).
//
// state | meaning
// EMPTY | y holds no unconsumed data (y_valid = 0)
// FULL  | y holds data waiting for y_ready (y_valid = 1)
module rr_arb_mux_2x1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b,
    output logic             ack_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_sel,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   last_sel;
    logic   space;
    logic   accept;

    assign y_valid = (state == FULL);

    always_comb begin
        sel       = last_sel;
        space     = 1'b0;
        accept    = 1'b0;
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        state_nxt = state;

        // On a tie the loser of the previous grant wins.
        if (req_a && req_b) begin
            sel = ~last_sel;
        end else if (req_a) begin
            sel = 1'b0;
        end else if (req_b) begin
            sel = 1'b1;
        end

        space  = (state == EMPTY) | y_ready;
        accept = ~rst & (req_a | req_b) & space;
        ack_a  = accept & ~sel;
        ack_b  = accept & sel;

        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (!accept && y_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            y        <= '0;
            y_sel    <= 1'b0;
            last_sel <= 1'b1;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                y        <= sel ? b : a;
                y_sel    <= sel;
                last_sel <= sel;
            end
            if (ack_a && (cnt_a != {CNT_W{1'b1}})) cnt_a <= cnt_a + CNT_W'(1);
            if (ack_b && (cnt_b != {CNT_W{1'b1}})) cnt_b <= cnt_b + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_2x1.sv
// Bench for rr_arb_mux_2x1: scoreboard of captured items plus directed checks,
// and a second narrow-counter instance for saturation.
module tb_rr_arb_mux_2x1;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_a = 1'b0, req_b = 1'b0, y_ready = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             ack_a, ack_b, sel, y_sel, y_valid;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    logic             s_req_a = 1'b0, s_req_b = 1'b0, s_y_ready = 1'b0;
    logic [WIDTH-1:0] s_a = '0, s_b = '0;
    logic             s_ack_a, s_ack_b, s_sel, s_y_sel, s_y_valid;
    logic [WIDTH-1:0] s_y;
    logic [1:0]       s_cnt_a, s_cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, mirrors the DUT registers as seen at each negedge.
    logic           mon_en      = 1'b0;
    logic           cap_pending = 1'b0;
    logic           m_valid     = 1'b0;
    logic           m_last_sel  = 1'b1;
    logic [7:0]     m_cnt_a     = '0;
    logic [7:0]     m_cnt_b     = '0;
    logic [WIDTH:0] sb_q[$];

    always #5 clk = ~clk;

    rr_arb_mux_2x1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .a(a), .ack_a(ack_a),
        .req_b(req_b), .b(b), .ack_b(ack_b),
        .sel(sel), .y(y), .y_sel(y_sel), .y_valid(y_valid), .y_ready(y_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    rr_arb_mux_2x1 #(.WIDTH(WIDTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .req_a(s_req_a), .a(s_a), .ack_a(s_ack_a),
        .req_b(s_req_b), .b(s_b), .ack_b(s_ack_b),
        .sel(s_sel), .y(s_y), .y_sel(s_y_sel), .y_valid(s_y_valid), .y_ready(s_y_ready),
        .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic           e_sel, e_acc;
        logic [WIDTH:0] item;
        if (mon_en) begin
            if (cap_pending) begin
                check_eq("sb_has_item", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    item = sb_q.pop_front();
                    check_eq("sb_y", y, item[WIDTH-1:0]);
                    check_eq("sb_y_sel", y_sel, item[WIDTH]);
                end
            end
            check_eq("sb_y_valid", y_valid, m_valid);
            check_eq("sb_cnt_a", cnt_a, m_cnt_a);
            check_eq("sb_cnt_b", cnt_b, m_cnt_b);

            e_sel = (req_a && req_b) ? ~m_last_sel : (req_b && !req_a);
            e_acc = !rst && (req_a || req_b) && (!m_valid || y_ready);
            check_eq("sb_ack_a", ack_a, e_acc && !e_sel);
            check_eq("sb_ack_b", ack_b, e_acc && e_sel);
            if (req_a || req_b) check_eq("sb_sel", sel, e_sel);

            if (rst) begin
                m_valid     = 1'b0;
                m_last_sel  = 1'b1;
                m_cnt_a     = '0;
                m_cnt_b     = '0;
                cap_pending = 1'b0;
                sb_q.delete();
            end else if (e_acc) begin
                sb_q.push_back({e_sel, e_sel ? b : a});
                m_last_sel  = e_sel;
                m_valid     = 1'b1;
                cap_pending = 1'b1;
                if (!e_sel && m_cnt_a != 8'hFF) m_cnt_a++;
                if (e_sel && m_cnt_b != 8'hFF) m_cnt_b++;
            end else begin
                cap_pending = 1'b0;
                if (y_ready) m_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Two reset edges, then idle.
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_y_valid", y_valid, 0);
        check_eq("idle_cnt_a", cnt_a, 0);
        check_eq("idle_cnt_b", cnt_b, 0);
        check_eq("idle_ack_a", ack_a, 0);
        check_eq("idle_ack_b", ack_b, 0);
        tick();

        // Single request from A.
        req_a = 1'b1; a = 8'h5A; y_ready = 1'b1;
        @(negedge clk);
        check_eq("single_ack_a", ack_a, 1);
        tick();
        req_a = 1'b0;
        @(negedge clk);
        check_eq("single_y", y, 8'h5A);
        check_eq("single_y_sel", y_sel, 0);
        check_eq("single_y_valid", y_valid, 1);
        check_eq("single_cnt_a", cnt_a, 1);
        tick();

        // Tie fairness from a fresh reset.
        rst = 1'b1; tick(); rst = 1'b0;
        req_a = 1'b1; req_b = 1'b1; a = 8'h11; b = 8'h22; y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_eq("tie_y", y, ((i - 1) % 2 == 0) ? 8'h11 : 8'h22);
                check_eq("tie_y_sel", y_sel, (i - 1) % 2);
            end
            check_eq("tie_ack_a", ack_a, (i % 2 == 0));
            check_eq("tie_ack_b", ack_b, (i % 2 == 1));
            tick();
        end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        check_eq("tie_y_last", y, 8'h22);
        check_eq("tie_y_sel_last", y_sel, 1);
        check_eq("tie_cnt_a", cnt_a, 2);
        check_eq("tie_cnt_b", cnt_b, 2);
        tick();

        // Backpressure: load 8'h11, then hold y_ready low while B waits.
        req_a = 1'b1; a = 8'h11; y_ready = 1'b0;
        @(negedge clk);
        check_eq("bp_load_ack_a", ack_a, 1);
        tick();
        req_a = 1'b0; req_b = 1'b1; b = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_hold_y", y, 8'h11);
            check_eq("bp_hold_valid", y_valid, 1);
            check_eq("bp_hold_ack_b", ack_b, 0);
            tick();
        end
        y_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ack_b", ack_b, 1);
        tick();
        req_b = 1'b0;
        @(negedge clk);
        check_eq("bp_y_b", y, 8'h33);
        check_eq("bp_y_sel_b", y_sel, 1);
        tick();

        // Reset mid-operation with both requesters pending.
        rst = 1'b1; tick(); rst = 1'b0;
        req_b = 1'b1; b = 8'h44; y_ready = 1'b1;
        tick();
        tick();
        req_a = 1'b1; a = 8'h55; y_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_eq("mid_pre_y_valid", y_valid, 1);
        check_eq("mid_pre_cnt_b", cnt_b, 2);
        check_eq("mid_rst_ack_a", ack_a, 0);
        check_eq("mid_rst_ack_b", ack_b, 0);
        tick();
        rst = 1'b0; y_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_post_y_valid", y_valid, 0);
        check_eq("mid_post_cnt_b", cnt_b, 0);
        check_eq("mid_post_ack_a", ack_a, 1);
        check_eq("mid_post_sel", sel, 0);
        tick();
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        check_eq("mid_post_y", y, 8'h55);
        check_eq("mid_post_y_sel", y_sel, 0);
        tick();
        tick();

        // Saturation on the 2-bit counter instance: five grants to A.
        s_req_a = 1'b1; s_a = 8'h77; s_y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) s_req_a = 1'b0;
            check_eq("sat_cnt_a", s_cnt_a, (i < 3) ? i + 1 : 3);
        end
        tick();
        tick();
        check_eq("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
